// File: rtl/spi_txn_sequencer.sv
// spi_txn_sequencer
// Queues 1..4 byte SPI requests and runs them one at a time through the
// SPI master control stage. Each transaction is framed by chip select,
// with setup and hold gaps around the control-stage enable. The received
// bytes, or an error flag, go back over a response handshake.

module spi_txn_sequencer #(
    parameter int FIFO_DEPTH      = 4,
    parameter int CS_SETUP_CYCLES = 22,
    parameter int CS_HOLD_CYCLES  = 22,
    parameter int TIMEOUT_CYCLES  = 4096
) (
    input  logic                          clk_i,
    input  logic                          rstn_i,
    input  logic                          req_valid_i,
    output logic                          req_ready_o,
    input  logic [31:0]                   req_wdata_i,
    input  logic [2:0]                    req_nbytes_i,
    output logic                          resp_valid_o,
    input  logic                          resp_ready_i,
    output logic [31:0]                   resp_rdata_o,
    output logic [2:0]                    resp_nbytes_o,
    output logic                          resp_err_o,
    output logic                          spi_cs_n_o,
    output logic                          ctrl_enable_o,
    output logic [31:0]                   ctrl_write_data_o,
    output logic [2:0]                    ctrl_bytes_valid_o,
    input  logic [31:0]                   ctrl_read_data_i,
    input  logic [2:0]                    ctrl_read_bytes_valid_i,
    input  logic                          ctrl_ready_i,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
    output logic                          busy_o
);

    localparam int AW      = $clog2(FIFO_DEPTH);
    localparam int LW      = AW + 1;
    localparam int CNT_MAX = (TIMEOUT_CYCLES > CS_SETUP_CYCLES)
                             ? ((TIMEOUT_CYCLES > CS_HOLD_CYCLES) ? TIMEOUT_CYCLES : CS_HOLD_CYCLES)
                             : ((CS_SETUP_CYCLES > CS_HOLD_CYCLES) ? CS_SETUP_CYCLES : CS_HOLD_CYCLES);
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_CS_SETUP  = 3'd1;
    localparam logic [2:0] ST_WAIT_DATA = 3'd2;
    localparam logic [2:0] ST_CS_HOLD   = 3'd3;
    localparam logic [2:0] ST_RESP      = 3'd4;

    logic [2:0]    state;
    logic [CW-1:0] cnt;

    logic [31:0]   mem_wdata  [FIFO_DEPTH];
    logic [2:0]    mem_nbytes [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    logic          fifo_empty;
    logic          push;
    logic          pop;
    logic [31:0]   head_wdata;
    logic [2:0]    head_nbytes;
    logic          head_legal;
    logic [31:0]   rx_aligned;

    assign fifo_empty  = (fifo_level_o == '0);
    assign req_ready_o = (fifo_level_o < LW'(FIFO_DEPTH));
    assign busy_o      = (state != ST_IDLE) || !fifo_empty;

    assign head_wdata  = mem_wdata[rd_ptr];
    assign head_nbytes = mem_nbytes[rd_ptr];
    assign head_legal  = (head_nbytes != 3'd0) && (head_nbytes <= 3'd4);

    assign push = req_valid_i && req_ready_o;
    assign pop  = (state == ST_IDLE) && !fifo_empty && (!head_legal || ctrl_ready_i);

    // Request storage write port.
    // NOTE: the storage array has no reset; validity is tracked by the pointers and level alone.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_wdata[wr_ptr]  <= req_wdata_i;
            mem_nbytes[wr_ptr] <= req_nbytes_i;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at FIFO_DEPTH.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_level_o <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   fifo_level_o <= fifo_level_o + LW'(1);
                2'b01:   fifo_level_o <= fifo_level_o - LW'(1);
                default: fifo_level_o <= fifo_level_o;
            endcase
        end
    end

    // Right-align the received bytes: the first byte on the wire lands most significant.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        rx_aligned = ctrl_read_data_i;
        case (ctrl_bytes_valid_o)
            3'd1:    rx_aligned = {24'd0, ctrl_read_data_i[31:24]};
            3'd2:    rx_aligned = {16'd0, ctrl_read_data_i[31:16]};
            3'd3:    rx_aligned = {8'd0,  ctrl_read_data_i[31:8]};
            default: rx_aligned = ctrl_read_data_i;
        endcase
    end

    // Transaction FSM: chip-select framing, enable, completion/timeout and response.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state              <= ST_IDLE;
            cnt                <= '0;
            spi_cs_n_o         <= 1'b1;
            ctrl_enable_o      <= 1'b0;
            ctrl_write_data_o  <= '0;
            ctrl_bytes_valid_o <= '0;
            resp_valid_o       <= 1'b0;
            resp_rdata_o       <= '0;
            resp_nbytes_o      <= '0;
            resp_err_o         <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        if (!head_legal) begin
                            // Illegal byte count: answer with an error, never touch the bus.
                            resp_err_o    <= 1'b1;
                            resp_rdata_o  <= '0;
                            resp_nbytes_o <= head_nbytes;
                            resp_valid_o  <= 1'b1;
                            state         <= ST_RESP;
                        end else if (ctrl_ready_i) begin
                            ctrl_write_data_o  <= head_wdata;
                            ctrl_bytes_valid_o <= head_nbytes;
                            spi_cs_n_o         <= 1'b0;
                            cnt                <= CW'(CS_SETUP_CYCLES - 1);
                            state              <= ST_CS_SETUP;
                        end
                    end
                end
                ST_CS_SETUP: begin
                    if (cnt == '0) begin
                        ctrl_enable_o <= 1'b1;
                        cnt           <= '0;
                        state         <= ST_WAIT_DATA;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                ST_WAIT_DATA: begin
                    // Completion wins over timeout when both land on the same cycle.
                    if (ctrl_read_bytes_valid_i == ctrl_bytes_valid_o) begin
                        resp_rdata_o  <= rx_aligned;
                        resp_err_o    <= 1'b0;
                        resp_nbytes_o <= ctrl_bytes_valid_o;
                        ctrl_enable_o <= 1'b0;
                        cnt           <= CW'(CS_HOLD_CYCLES - 1);
                        state         <= ST_CS_HOLD;
                    end else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                        resp_rdata_o  <= '0;
                        resp_err_o    <= 1'b1;
                        resp_nbytes_o <= ctrl_bytes_valid_o;
                        ctrl_enable_o <= 1'b0;
                        cnt           <= CW'(CS_HOLD_CYCLES - 1);
                        state         <= ST_CS_HOLD;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ST_CS_HOLD: begin
                    if (cnt == '0) begin
                        spi_cs_n_o   <= 1'b1;
                        resp_valid_o <= 1'b1;
                        state        <= ST_RESP;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                ST_RESP: begin
                    if (resp_ready_i) begin
                        resp_valid_o <= 1'b0;
                        state        <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_txn_sequencer.sv
// Testbench for spi_txn_sequencer: a behavioural control-stage model, a
// response scoreboard and a chip-select timing monitor, driven by directed
// and randomized request streams.

module tb_spi_txn_sequencer;

    localparam int DEPTH    = 4;
    localparam int CS_SETUP = 22;
    localparam int CS_HOLD  = 22;
    localparam int TIMEOUT  = 64;

    typedef struct {
        logic [31:0] wdata;
        logic [2:0]  n;
        logic [31:0] rd;
        bit          hang;
    } plan_t;

    typedef struct {
        logic [31:0] rdata;
        logic [2:0]  n;
        logic        err;
    } resp_t;

    logic        clk_i;
    logic        rstn_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [31:0] req_wdata_i;
    logic [2:0]  req_nbytes_i;
    logic        resp_valid_o;
    logic        resp_ready_i;
    logic [31:0] resp_rdata_o;
    logic [2:0]  resp_nbytes_o;
    logic        resp_err_o;
    logic        spi_cs_n_o;
    logic        ctrl_enable_o;
    logic [31:0] ctrl_write_data_o;
    logic [2:0]  ctrl_bytes_valid_o;
    logic [31:0] ctrl_read_data_i;
    logic [2:0]  ctrl_read_bytes_valid_i;
    logic        ctrl_ready_i;
    logic [2:0]  fifo_level_o;
    logic        busy_o;

    int    checks   = 0;
    int    failures = 0;
    int    cs_falls = 0;
    int    en_rises = 0;
    bit    resp_block = 0;
    plan_t plan_q[$];
    resp_t exp_q[$];

    // Monitor state
    bit prev_cs;
    bit prev_en;
    int setup_cnt;
    int hold_cnt;
    bit hold_active;

    spi_txn_sequencer #(
        .FIFO_DEPTH      (DEPTH),
        .CS_SETUP_CYCLES (CS_SETUP),
        .CS_HOLD_CYCLES  (CS_HOLD),
        .TIMEOUT_CYCLES  (TIMEOUT)
    ) dut (
        .clk_i                   (clk_i),
        .rstn_i                  (rstn_i),
        .req_valid_i             (req_valid_i),
        .req_ready_o             (req_ready_o),
        .req_wdata_i             (req_wdata_i),
        .req_nbytes_i            (req_nbytes_i),
        .resp_valid_o            (resp_valid_o),
        .resp_ready_i            (resp_ready_i),
        .resp_rdata_o            (resp_rdata_o),
        .resp_nbytes_o           (resp_nbytes_o),
        .resp_err_o              (resp_err_o),
        .spi_cs_n_o              (spi_cs_n_o),
        .ctrl_enable_o           (ctrl_enable_o),
        .ctrl_write_data_o       (ctrl_write_data_o),
        .ctrl_bytes_valid_o      (ctrl_bytes_valid_o),
        .ctrl_read_data_i        (ctrl_read_data_i),
        .ctrl_read_bytes_valid_i (ctrl_read_bytes_valid_i),
        .ctrl_ready_i            (ctrl_ready_i),
        .fifo_level_o            (fifo_level_o),
        .busy_o                  (busy_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h expected=0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Spec rule: legal N returns the N received bytes right-aligned, first byte most significant.
    function automatic resp_t model_resp(input plan_t p);
        resp_t r;
        int    nn;
        nn      = int'(p.n);
        r.n     = p.n;
        if (nn < 1 || nn > 4 || p.hang) begin
            r.rdata = 32'd0;
            r.err   = 1'b1;
        end else begin
            r.rdata = p.rd >> (8 * (4 - nn));
            r.err   = 1'b0;
        end
        return r;
    endfunction

    task automatic push(input logic [31:0] wd, input logic [2:0] n, input logic [31:0] rd, input bit hang);
        plan_t p;
        int    waited;
        waited = 0;
        p.wdata = wd;
        p.n     = n;
        p.rd    = rd;
        p.hang  = hang;
        @(negedge clk_i);
        req_valid_i  = 1'b1;
        req_wdata_i  = wd;
        req_nbytes_i = n;
        while (!req_ready_o && waited < 3000) begin
            @(negedge clk_i);
            waited++;
        end
        if (!req_ready_o) begin
            check("push_ready_timeout", 32'd0, 32'd1);
        end else begin
            @(posedge clk_i);
            if (n >= 3'd1 && n <= 3'd4) plan_q.push_back(p);
            exp_q.push_back(model_resp(p));
        end
        @(negedge clk_i);
        req_valid_i = 1'b0;
    endtask

    task automatic wait_idle();
        int waited;
        waited = 0;
        while ((exp_q.size() != 0 || busy_o) && waited < 6000) begin
            @(negedge clk_i);
            waited++;
        end
        check("wait_idle_timeout", 32'(waited >= 6000), 32'd0);
        repeat (2) @(negedge clk_i);
    endtask

    // Behavioural control stage: on each enable it checks the request it was
    // handed, then either never completes or reports a byte-count ramp 1..N.
    initial begin : ctrl_model
        plan_t p;
        int    en_cycles;
        int    gap;
        ctrl_read_data_i        = 32'd0;
        ctrl_read_bytes_valid_i = 3'd0;
        forever begin
            @(posedge clk_i);
            #1;
            if (rstn_i && ctrl_enable_o) begin
                if (plan_q.size() == 0) begin
                    check("ctrl_unexpected_enable", 32'd1, 32'd0);
                    en_cycles = 0;
                    while (ctrl_enable_o && en_cycles < 10000) begin
                        @(posedge clk_i);
                        #1;
                        en_cycles++;
                    end
                end else begin
                    p = plan_q.pop_front();
                    check("ctrl_write_data", ctrl_write_data_o, p.wdata);
                    check("ctrl_bytes_valid", 32'(ctrl_bytes_valid_o), 32'(p.n));
                    if (p.hang) begin
                        en_cycles = 1;
                        while (ctrl_enable_o && en_cycles < 10000) begin
                            @(posedge clk_i);
                            #1;
                            if (ctrl_enable_o) en_cycles++;
                        end
                        if (rstn_i) check("timeout_enable_cycles", 32'(en_cycles), 32'(TIMEOUT));
                    end else begin
                        gap = int'($urandom_range(0, 4));
                        repeat (gap) begin
                            @(posedge clk_i);
                            #1;
                        end
                        for (int v = 1; v < int'(p.n); v++) begin
                            ctrl_read_bytes_valid_i = 3'(v);
                            ctrl_read_data_i        = $urandom;
                            @(posedge clk_i);
                            #1;
                        end
                        ctrl_read_bytes_valid_i = p.n;
                        ctrl_read_data_i        = p.rd;
                        @(posedge clk_i);
                        #1;
                        check("enable_drop_on_done", 32'(ctrl_enable_o), 32'd0);
                        ctrl_read_bytes_valid_i = 3'd0;
                        ctrl_read_data_i        = 32'd0;
                        en_cycles = 0;
                        while (ctrl_enable_o && en_cycles < 10000) begin
                            @(posedge clk_i);
                            #1;
                            en_cycles++;
                        end
                    end
                end
                ctrl_read_bytes_valid_i = 3'd0;
                ctrl_read_data_i        = 32'd0;
            end
        end
    end

    // Chip-select framing monitor: setup and hold gap around enable.
    initial begin : cs_monitor
        prev_cs     = 1'b1;
        prev_en     = 1'b0;
        setup_cnt   = 0;
        hold_cnt    = 0;
        hold_active = 1'b0;
        forever begin
            @(posedge clk_i);
            #1;
            if (!rstn_i) begin
                prev_cs     = 1'b1;
                prev_en     = 1'b0;
                setup_cnt   = 0;
                hold_cnt    = 0;
                hold_active = 1'b0;
            end else begin
                if (prev_cs && !spi_cs_n_o) begin
                    cs_falls++;
                    setup_cnt = 0;
                    check("cs_fall_while_resp_pending", 32'(resp_valid_o), 32'd0);
                end
                if (!prev_en && ctrl_enable_o) begin
                    en_rises++;
                    check("cs_setup_cycles", 32'(setup_cnt), 32'(CS_SETUP));
                end
                if (prev_en && !ctrl_enable_o) begin
                    hold_active = 1'b1;
                    hold_cnt    = 0;
                end
                if (!spi_cs_n_o && !ctrl_enable_o) begin
                    if (hold_active) hold_cnt++;
                    else             setup_cnt++;
                end
                if (hold_active && spi_cs_n_o) begin
                    check("cs_hold_cycles", 32'(hold_cnt), 32'(CS_HOLD));
                    hold_active = 1'b0;
                end
                prev_cs = spi_cs_n_o;
                prev_en = ctrl_enable_o;
            end
        end
    end

    // Response side: random back-pressure, scoreboard compare, hold-stable check.
    initial begin : resp_side
        resp_t snap;
        resp_t e;
        bit    stall;
        stall        = 1'b0;
        resp_ready_i = 1'b0;
        forever begin
            @(negedge clk_i);
            if (!rstn_i) begin
                resp_ready_i = 1'b0;
                stall        = 1'b0;
            end else begin
                if (stall) begin
                    check("resp_stable_valid", 32'(resp_valid_o), 32'd1);
                    check("resp_stable_rdata", resp_rdata_o, snap.rdata);
                    check("resp_stable_err_n", {28'd0, resp_err_o, resp_nbytes_o}, {28'd0, snap.err, snap.n});
                end
                resp_ready_i = resp_block ? 1'b0 : ($urandom_range(0, 2) != 0);
                stall        = 1'b0;
                if (resp_valid_o) begin
                    if (resp_ready_i) begin
                        if (exp_q.size() == 0) begin
                            check("resp_unexpected", 32'd1, 32'd0);
                        end else begin
                            e = exp_q.pop_front();
                            check("resp_rdata", resp_rdata_o, e.rdata);
                            check("resp_nbytes", 32'(resp_nbytes_o), 32'(e.n));
                            check("resp_err", 32'(resp_err_o), 32'(e.err));
                        end
                    end else begin
                        stall      = 1'b1;
                        snap.rdata = resp_rdata_o;
                        snap.n     = resp_nbytes_o;
                        snap.err   = resp_err_o;
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #400000;
        failures++;
        $display("FAIL watchdog simulation did not finish got=running expected=done");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cs_n"},    32'(spi_cs_n_o), 32'd1);
        check({tag, "_enable"},  32'(ctrl_enable_o), 32'd0);
        check({tag, "_level"},   32'(fifo_level_o), 32'd0);
        check({tag, "_rvalid"},  32'(resp_valid_o), 32'd0);
        check({tag, "_rdata"},   resp_rdata_o, 32'd0);
        check({tag, "_rerr_n"},  {28'd0, resp_err_o, resp_nbytes_o}, 32'd0);
        check({tag, "_ctrl_wd"}, ctrl_write_data_o, 32'd0);
        check({tag, "_ctrl_n"},  32'(ctrl_bytes_valid_o), 32'd0);
        check({tag, "_ready"},   32'(req_ready_o), 32'd1);
        check({tag, "_busy"},    32'(busy_o), 32'd0);
    endtask

    initial begin : main
        int lat;
        int falls0;
        int rises0;
        int seen_valid;
        int waited;
        int r;
        logic [2:0] n;
        bit hang;

        rstn_i       = 1'b0;
        req_valid_i  = 1'b0;
        req_wdata_i  = 32'd0;
        req_nbytes_i = 3'd0;
        ctrl_ready_i = 1'b1;
        repeat (3) @(negedge clk_i);
        check_reset_outputs("reset");
        rstn_i = 1'b1;
        repeat (2) @(negedge clk_i);
        check_reset_outputs("after_release");

        // Directed: 3-byte transfer, chip-select latency
        push(32'h00A1B2C3, 3'd3, 32'hDEADBE00, 1'b0);
        lat = 1;
        while (spi_cs_n_o && lat < 10) begin
            @(negedge clk_i);
            lat++;
        end
        check("cs_fall_latency", 32'(lat), 32'd2);
        wait_idle();

        // Directed: back-to-back 1-byte and 4-byte requests
        push(32'h00000011, 3'd1, 32'h5A000000, 1'b0);
        push(32'hCAFEF00D, 3'd4, 32'h01020304, 1'b0);
        wait_idle();
        check("two_txn_cs_falls", 32'(cs_falls), 32'd3);

        // Directed: illegal byte counts never touch the bus
        falls0 = cs_falls;
        rises0 = en_rises;
        push(32'h12345678, 3'd0, 32'd0, 1'b0);
        push(32'h87654321, 3'd6, 32'd0, 1'b0);
        wait_idle();
        check("illegal_no_cs", 32'(cs_falls), 32'(falls0));
        check("illegal_no_enable", 32'(en_rises), 32'(rises0));

        // Directed: timeout, then a normal request behind it
        push(32'h0000BEEF, 3'd2, 32'd0, 1'b1);
        push(32'hA5A5A5A5, 3'd4, 32'h89ABCDEF, 1'b0);
        wait_idle();

        // Directed: FIFO full with stalled responses and control stage not ready
        resp_block   = 1'b1;
        ctrl_ready_i = 1'b0;
        for (int i = 0; i < DEPTH; i++) push($urandom, 3'(i + 1), $urandom, 1'b0);
        check("full_level", 32'(fifo_level_o), 32'(DEPTH));
        check("full_ready_low", 32'(req_ready_o), 32'd0);
        check("full_busy", 32'(busy_o), 32'd1);
        req_valid_i  = 1'b1;
        req_wdata_i  = 32'h00005555;
        req_nbytes_i = 3'd2;
        repeat (4) @(negedge clk_i);
        check("full_no_accept_level", 32'(fifo_level_o), 32'(DEPTH));
        ctrl_ready_i = 1'b1;
        push(32'h00005555, 3'd2, 32'hC3C30000, 1'b0);
        waited = 0;
        while (!resp_valid_o && waited < 500) begin
            @(negedge clk_i);
            waited++;
        end
        check("stall_resp_valid", 32'(resp_valid_o), 32'd1);
        repeat (20) @(negedge clk_i);
        check("stall_level", 32'(fifo_level_o), 32'(DEPTH));
        resp_block = 1'b0;
        wait_idle();

        // Reset during WAIT_DATA with one request still queued
        push(32'h0000F00F, 3'd2, 32'd0, 1'b1);
        push(32'h11223344, 3'd4, 32'h55667788, 1'b0);
        waited = 0;
        while (!ctrl_enable_o && waited < 200) begin
            @(negedge clk_i);
            waited++;
        end
        check("pre_reset_enable", 32'(ctrl_enable_o), 32'd1);
        repeat (5) @(negedge clk_i);
        #2;
        rstn_i = 1'b0;
        plan_q.delete();
        exp_q.delete();
        #1;
        check("midreset_cs_n", 32'(spi_cs_n_o), 32'd1);
        check("midreset_enable", 32'(ctrl_enable_o), 32'd0);
        check("midreset_level", 32'(fifo_level_o), 32'd0);
        check("midreset_rvalid", 32'(resp_valid_o), 32'd0);
        repeat (3) @(negedge clk_i);
        rstn_i = 1'b1;
        falls0     = cs_falls;
        seen_valid = 0;
        repeat (60) begin
            @(negedge clk_i);
            if (resp_valid_o) seen_valid++;
        end
        check("post_reset_no_resp", 32'(seen_valid), 32'd0);
        check("post_reset_no_cs", 32'(cs_falls), 32'(falls0));

        // Randomized stream
        for (int k = 0; k < 16; k++) begin
            r = int'($urandom_range(0, 9));
            if (r < 8) n = 3'(1 + (r % 4));
            else if (r == 8) n = 3'd0;
            else n = 3'($urandom_range(5, 7));
            hang = ($urandom_range(0, 9) == 0);
            push($urandom, n, $urandom, hang);
            repeat ($urandom_range(0, 3)) @(negedge clk_i);
        end
        wait_idle();
        check("final_exp_empty", 32'(exp_q.size()), 32'd0);
        check("final_plan_empty", 32'(plan_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
